// File: rtl/fetch_pkg.sv
// Shared fetch types: NOP encoding, default reset PC and the queue entry layout.
// Pure declarations: no latency, no flow control.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        oob;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch entries; head visible the cycle after push-into-empty (no bypass).
// Caller must not push when full unless it pops that cycle; flush empties in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       head_valid,
    output fetch_entry_t               head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  store [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   used;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign used       = wr_ptr - rd_ptr;
    assign count      = CW'(used);
    assign head_valid = (wr_ptr != rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = store[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) store[wr_ptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer feeding decode through a prefetch queue; fetch-to-decode 1 cycle, redirect-to-decode 2.
// Stalls PC when queue full and not popping; FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_instr,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       fd_valid,
    input  logic                       fd_ready,
    output logic [31:0]                fd_pc,
    output logic [31:0]                fd_instr,
    output logic                       fd_oob,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                       fetch_fault,
`endif
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    logic [31:0]  pc;
    logic [31:0]  target_pc;
    logic         fault_q;
    logic         do_pop;
    logic         do_push;
    logic         q_full;
    logic         head_valid;
    fetch_entry_t head;
    fetch_entry_t new_entry;

    assign imem_addr = pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_pc   = redirect_pc;
    assign fetch_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fault_q <= 1'b0;
        else if (redirect_valid) fault_q <= |redirect_pc[1:0];
    end
`else
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign fault_q   = 1'b0;
`endif

    // A redirect squashes whatever decode sees this cycle, so its pop is dropped.
    assign do_pop  = head_valid && fd_ready && !redirect_valid;
    assign do_push = fetch_en && !redirect_valid && !fault_q && (!q_full || do_pop);

    assign new_entry.pc    = pc;
    assign new_entry.instr = imem_instr;
    assign new_entry.oob   = ({2'b00, pc[31:2]} >= 32'(MEM_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pc <= RESET_PC;
        else if (redirect_valid) pc <= target_pc;
        else if (do_push)        pc <= pc + 32'd4;
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (do_push),
        .push_entry (new_entry),
        .pop        (do_pop),
        .flush      (redirect_valid),
        .count      (q_count),
        .full       (q_full),
        .head_valid (head_valid),
        .head       (head)
    );

    assign fd_valid = head_valid;
    assign fd_pc    = head_valid ? head.pc    : 32'h0;
    assign fd_instr = head_valid ? head.instr : NOP_INSTR;
    assign fd_oob   = head_valid && head.oob;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a queue-based reference model predicts every delivered entry,
// and an independent monitor pops and compares whenever decode accepts one.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int DEPTH = 2;
    localparam int MW    = 1024;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_valid;
    logic        fd_ready;
    logic [31:0] fd_pc;
    logic [31:0] fd_instr;
    logic        fd_oob;
    logic [1:0]  q_count;
    logic        fetch_fault;

    logic [31:0] mem [MW];
    assign imem_instr = mem[imem_addr[11:2]];

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH), .MEM_WORDS(MW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_ready       (fd_ready),
        .fd_pc          (fd_pc),
        .fd_instr       (fd_instr),
        .fd_oob         (fd_oob),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault    (fetch_fault),
`endif
        .q_count        (q_count)
    );
`ifndef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = 1'b0;
`endif

    // Reference model: expected deliveries in order, plus architectural PC and fault flag.
    fetch_entry_t exp_q [$];
    logic [31:0]  m_pc;
    bit           m_fault;
    int           cur_cnt;
    fetch_entry_t cur_head;
    logic [31:0]  cur_pc;
    bit           cur_fault;
    bit           started = 1'b0;
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit en, input bit rdy, input bit rv, input logic [31:0] rpc);
        fetch_entry_t e;
        bit pop;
        @(negedge clk); #1;
        fetch_en = en; fd_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        cur_cnt = exp_q.size(); cur_pc = m_pc; cur_fault = m_fault;
        if (cur_cnt > 0) cur_head = exp_q[0];
        started = 1'b1;
        pop = (cur_cnt > 0) && rdy && !rv;
        if (rv) begin
            exp_q.delete();
            m_fault = TRAP && (rpc[1:0] != 2'b00);
            m_pc = TRAP ? rpc : {rpc[31:2], 2'b00};
        end else if (en && !m_fault && (cur_cnt < DEPTH || pop)) begin
            e.pc = m_pc;
            e.instr = mem[m_pc[11:2]];
            e.oob = (m_pc >= 32'h1000);
            exp_q.push_back(e);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; fetch_en = 0; fd_ready = 0; redirect_valid = 0; redirect_pc = '0;
        exp_q.delete(); m_pc = 32'h0; m_fault = 0;
        cur_cnt = 0; cur_pc = 32'h0; cur_fault = 0;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: samples after the stimulus settles, before the next rising edge.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk); #2;
            if (started) begin
                check("q_count", 32'(q_count), 32'(cur_cnt));
                check("fd_valid", 32'(fd_valid), 32'(cur_cnt != 0));
                check("imem_addr", imem_addr, cur_pc);
                if (TRAP) check("fetch_fault", 32'(fetch_fault), 32'(cur_fault));
                if (cur_cnt != 0 && fd_valid && fd_ready && !redirect_valid) begin
                    e = exp_q.pop_front();
                    check("pop_pc", fd_pc, e.pc);
                    check("pop_instr", fd_instr, e.instr);
                    check("pop_oob", 32'(fd_oob), 32'(e.oob));
                end else if (cur_cnt != 0) begin
                    check("head_pc", fd_pc, cur_head.pc);
                    check("head_instr", fd_instr, cur_head.instr);
                    check("head_oob", 32'(fd_oob), 32'(cur_head.oob));
                end else begin
                    check("idle_pc", fd_pc, 32'h0);
                    check("idle_instr", fd_instr, NOP_INSTR);
                    check("idle_oob", 32'(fd_oob), 32'h0);
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        for (int i = 0; i < MW; i++) mem[i] = $urandom;
        mem[0] = 32'h0140_0313;
        rst_n = 1'b0; fetch_en = 0; fd_ready = 0; redirect_valid = 0; redirect_pc = '0;
        exp_q.delete(); m_pc = 32'h0; m_fault = 0;
        #12;
        check("rst_fd_valid", 32'(fd_valid), 32'h0);
        check("rst_fd_pc", fd_pc, 32'h0);
        check("rst_fd_instr", fd_instr, NOP_INSTR);
        check("rst_fd_oob", 32'(fd_oob), 32'h0);
        check("rst_q_count", 32'(q_count), 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_first_word", imem_instr, 32'h0140_0313);
        @(negedge clk); #1;
        rst_n = 1'b1;

        repeat (14) step(1, 1, 0, 0);                 // streaming
        repeat (5)  step(1, 0, 0, 0);                 // stall to full
        repeat (4)  step(1, 1, 0, 0);
        repeat (3)  step(1, 0, 0, 0);
        step(1, 0, 1, 32'h20);                        // redirect while full
        repeat (4)  step(1, 1, 0, 0);
        step(1, 1, 1, 32'h40);                        // push+pop+redirect together
        repeat (4)  step(1, 1, 0, 0);
        step(1, 1, 1, 32'hFFC);                       // memory boundary
        repeat (4)  step(1, 1, 0, 0);
        step(1, 1, 1, 32'h22);                        // misaligned target
        repeat (3)  step(1, 1, 0, 0);
        step(1, 1, 1, 32'h24);
        repeat (3)  step(1, 1, 0, 0);
        step(1, 1, 1, 32'hFFFF_FFF8);                 // PC wrap
        repeat (4)  step(1, 1, 0, 0);
        step(0, 1, 1, 32'h80);                        // redirect with fetch disabled
        repeat (2)  step(0, 1, 0, 0);
        step(1, 1, 1, 32'h100);                       // back-to-back redirects
        step(1, 1, 1, 32'h200);
        repeat (3)  step(1, 0, 0, 0);
        do_reset();                                   // reset with entries in flight
        repeat (3)  step(1, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                rpc = 32'($urandom_range(0, 1100)) << 2;
                if ($urandom_range(0, 7) == 0) rpc = rpc | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF0;
                step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 15) == 0, rpc);
            end
        end
        step(0, 1, 0, 0);
        @(negedge clk); #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer between the pipeline's IF stage and the combinational instruction memory (`addr` in, `instr` out, word index = `addr >> 2`).
- Owns the PC and drives the memory address each cycle.
- Captures fetched words into a small prefetch queue and hands {pc, instr} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, prefetch queue entries (power of two, 2..8).
- MEM_WORDS, 1024, instruction memory size in words; used for the out-of-range check.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  byte address to instruction memory; equals current PC.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- fetch_en  input  1  1 = fetching allowed; 0 = hold PC, no pushes, queue still drains.
- redirect_valid  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  32  redirect target byte address.
- fd_valid  output  1  queue head valid toward decode.
- fd_ready  input  1  decode accepts head this cycle.
- fd_pc  output  32  PC of head entry.
- fd_instr  output  32  instruction of head entry; 32'h00000013 (NOP) when fd_valid=0.
- fd_oob  output  1  head entry was fetched from PC >= 4*MEM_WORDS.
- q_count  output  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - pc = RESET_PC, queue empty.
  - fd_valid = 0, fd_pc = 0, fd_instr = 32'h00000013, fd_oob = 0, q_count = 0.
  - imem_addr = RESET_PC.
- imem_addr is pc at all times. The memory is combinational, so the word for pc is available in the same cycle.
- Pop: occurs when fd_valid && fd_ready.
- Push: occurs when fetch_en && !redirect_valid && (q_count < DEPTH || pop).
  - Pushes {pc, imem_instr, oob}, where oob = (pc >> 2) >= MEM_WORDS.
  - On push, pc <= pc + 4, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
- Full queue: a push and pop in the same cycle are both honoured and q_count is unchanged.
- Empty queue: a push makes the entry visible on fd_* the next cycle. There is no same-cycle bypass, so fetch-to-decode latency is 1 cycle.
- Redirect (highest priority):
  - pc <= redirect_pc, queue cleared, no push that cycle.
  - A pop in the same cycle is ignored; decode must treat fd_* as squashed.
  - Next cycle: fd_valid = 0 and imem_addr = redirect_pc.
  - First redirected entry is visible 2 cycles after redirect_valid.
- Redirect with fetch_en = 0: pc is still reloaded and the queue flushed.
- Back-to-back redirects: the last one wins and each flushes.
- Queue ordering is strict FIFO. Head registers update only on pop, push-into-empty, flush or reset.
- Reset asserted mid-operation: all state, including in-flight entries, is discarded immediately.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 loads pc, flushes the queue, sets fetch_fault = 1 and suppresses all pushes.
  - fetch_fault clears on the next aligned redirect or on reset.
- Undefined:
  - No port.
  - redirect_pc[1:0] is ignored; pc is loaded with {redirect_pc[31:2], 2'b00}.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR = 32'h00000013.
  - Default RESET_PC.
  - Packed struct fetch_entry_t {pc[31:0], instr[31:0], oob}.
- Sub-module fetch_queue:
  - Generic DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, head outputs.
  - Pointers one bit wider than log2(DEPTH) for full/empty detection.
- fetch_ctrl itself contains only the PC register, push/redirect logic and the optional fault flag.

Test Plan:
1. Reset, then fetch_en=1, fd_ready=1, memory preloaded with words 0..12 → fd_pc sequence 0,4,8,… one per cycle from cycle 1; fd_instr matches mem[0..12]; first word 32'h01400313.
2. fd_ready=0 for 5 cycles with fetch_en=1 → q_count reaches DEPTH=2; imem_addr holds at 8; release fd_ready → pcs 0,4,8 delivered in order, no loss or duplicate.
3. redirect_valid with redirect_pc=32'h20 while queue full → next cycle fd_valid=0, q_count=0, imem_addr=0x20; two cycles later fd_pc=0x20.
4. Simultaneous push, pop and redirect → pop ignored, no push, queue empty; fetching resumes at the target.
5. Redirect to 32'hFFC with MEM_WORDS=1024, then one more fetch → first entry fd_oob=0, next entry (pc 0x1000) fd_oob=1.
6. With FETCH_MISALIGN_TRAP_EN, redirect to 0x22 → fetch_fault=1, fd_valid stays 0; then redirect to 0x24 → fault clears and fd_pc=0x24 follows. Without the macro, the same first redirect → fd_pc=0x20.
